// File: rtl/rgb_sequencer.sv
// Colour-sequence controller: walks a small table of RGB duty targets,
// slewing each channel toward its target on a slow fade tick, then holding.
module rgb_sequencer #(
  parameter int PWM_MAX   = 1200,
  parameter int TICK_DIV  = 5000,
  parameter int NUM_STEPS = 4,
  parameter int DUTY_W    = 11,
  parameter int CNT_W     = 10,
  parameter int AW        = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DUTY_W-1:0] cfg_r,
  input  logic [DUTY_W-1:0] cfg_g,
  input  logic [DUTY_W-1:0] cfg_b,
  input  logic [CNT_W-1:0]  cfg_rate,
  input  logic [CNT_W-1:0]  cfg_hold,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              busy,
  output logic [AW-1:0]     step_idx,
  output logic              step_done
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW1   = DUTY_W + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RAMP, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DUTY_W-1:0]   duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [DUTY_W-1:0]   tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
  logic [CNT_W-1:0]    rate_q, rate_d, hold_q, hold_d, hold_cnt_q, hold_cnt_d;
  logic                done_q, done_d;
  logic                tick, all_met;

  logic [DUTY_W-1:0]   tbl_r_q [NUM_STEPS];
  logic [DUTY_W-1:0]   tbl_g_q [NUM_STEPS];
  logic [DUTY_W-1:0]   tbl_b_q [NUM_STEPS];
  logic [CNT_W-1:0]    tbl_rate_q [NUM_STEPS];
  logic [CNT_W-1:0]    tbl_hold_q [NUM_STEPS];
  logic [DUTY_W-1:0]   tbl_r_d [NUM_STEPS];
  logic [DUTY_W-1:0]   tbl_g_d [NUM_STEPS];
  logic [DUTY_W-1:0]   tbl_b_d [NUM_STEPS];
  logic [CNT_W-1:0]    tbl_rate_d [NUM_STEPS];
  logic [CNT_W-1:0]    tbl_hold_d [NUM_STEPS];

  function automatic logic [DUTY_W-1:0] clamp(input logic [DUTY_W-1:0] v);
    return (int'(v) > PWM_MAX) ? DUTY_W'(PWM_MAX) : v;
  endfunction

  // Move cur toward tgt by at most rate; snaps to tgt so it never overshoots.
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                             input logic [DUTY_W-1:0] tgt,
                                             input logic [CNT_W-1:0]  rate);
    logic signed [DUTY_W:0] diff;
    logic [DUTY_W:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
    if (rate == '0 || mag <= DW1'(rate)) return tgt;
    else if (diff[DUTY_W])                return cur - DUTY_W'(rate);
    else                                  return cur + DUTY_W'(rate);
  endfunction

  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
  assign all_met = (duty_r_q == tgt_r_q) && (duty_g_q == tgt_g_q) && (duty_b_q == tgt_b_q);

  always_comb begin
    tbl_r_d    = tbl_r_q;
    tbl_g_d    = tbl_g_q;
    tbl_b_d    = tbl_b_q;
    tbl_rate_d = tbl_rate_q;
    tbl_hold_d = tbl_hold_q;
    if (cfg_we && int'(cfg_addr) < NUM_STEPS) begin
      tbl_r_d[cfg_addr]    = clamp(cfg_r);
      tbl_g_d[cfg_addr]    = clamp(cfg_g);
      tbl_b_d[cfg_addr]    = clamp(cfg_b);
      tbl_rate_d[cfg_addr] = cfg_rate;
      tbl_hold_d[cfg_addr] = cfg_hold;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    idx_d      = idx_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    tgt_r_d    = tgt_r_q;
    tgt_g_d    = tgt_g_q;
    tgt_b_d    = tgt_b_q;
    rate_d     = rate_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          div_d   = '0;
        end
        S_LOAD: begin
          tgt_r_d    = tbl_r_q[idx_q];
          tgt_g_d    = tbl_g_q[idx_q];
          tgt_b_d    = tbl_b_q[idx_q];
          rate_d     = tbl_rate_q[idx_q];
          hold_d     = tbl_hold_q[idx_q];
          hold_cnt_d = '0;
          state_d    = S_RAMP;
        end
        S_RAMP: begin
          if (all_met) begin
            state_d = S_HOLD;
          end else if (tick) begin
            duty_r_d = slew(duty_r_q, tgt_r_q, rate_q);
            duty_g_d = slew(duty_g_q, tgt_g_q, rate_q);
            duty_b_d = slew(duty_b_q, tgt_b_q, rate_q);
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == hold_q) begin
            done_d = 1'b1;
            if (idx_q == LAST_IDX && !loop_en) begin
              state_d = S_IDLE;
            end else begin
              idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
              state_d = S_LOAD;
            end
          end else if (tick) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: the table is reset along with the control state so a reset always yields a known, all-zero pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      div_q      <= '0;
      duty_r_q   <= '0;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      tgt_r_q    <= '0;
      tgt_g_q    <= '0;
      tgt_b_q    <= '0;
      rate_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      tbl_r_q    <= '{default: '0};
      tbl_g_q    <= '{default: '0};
      tbl_b_q    <= '{default: '0};
      tbl_rate_q <= '{default: '0};
      tbl_hold_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      tgt_r_q    <= tgt_r_d;
      tgt_g_q    <= tgt_g_d;
      tgt_b_q    <= tgt_b_d;
      rate_q     <= rate_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      tbl_r_q    <= tbl_r_d;
      tbl_g_q    <= tbl_g_d;
      tbl_b_q    <= tbl_b_d;
      tbl_rate_q <= tbl_rate_d;
      tbl_hold_q <= tbl_hold_d;
    end
  end

  assign duty_r    = duty_r_q;
  assign duty_g    = duty_g_q;
  assign duty_b    = duty_b_q;
  assign busy      = (state_q != S_IDLE);
  assign step_idx  = idx_q;
  assign step_done = done_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer: expected duty changes and step_done
// events (with cycle offsets from the accepted start) are queued and popped by a monitor.
module tb_rgb_sequencer;

  localparam int DUTY_W = 11;
  localparam int CNT_W  = 10;
  localparam int AW     = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DUTY_W-1:0] cfg_r = '0, cfg_g = '0, cfg_b = '0;
  logic [CNT_W-1:0]  cfg_rate = '0, cfg_hold = '0;
  logic              start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [DUTY_W-1:0] duty_r, duty_g, duty_b;
  logic              busy, step_done;
  logic [AW-1:0]     step_idx;

  rgb_sequencer #(
    .PWM_MAX(1200), .TICK_DIV(4), .NUM_STEPS(2), .DUTY_W(DUTY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .cfg_rate(cfg_rate), .cfg_hold(cfg_hold),
    .start(start), .stop(stop), .loop_en(loop_en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .busy(busy), .step_idx(step_idx), .step_done(step_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int idx;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t duty_q[$];
  exp_t done_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  task automatic push_d(input int t, input int r, input int g, input int b);
    exp_t e;
    e.t = t; e.idx = 0; e.r = r; e.g = g; e.b = b;
    duty_q.push_back(e);
  endtask

  task automatic push_done(input int t, input int idx, input int r, input int g, input int b);
    exp_t e;
    e.t = t; e.idx = idx; e.r = r; e.g = g; e.b = b;
    done_q.push_back(e);
  endtask

  // Monitor: any duty change or step_done pulse must match the head of its queue.
  logic [DUTY_W-1:0] prev_r = '0, prev_g = '0, prev_b = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_r = duty_r; prev_g = duty_g; prev_b = duty_b;
    end else begin
      if (duty_r != prev_r || duty_g != prev_g || duty_b != prev_b) begin
        if (duty_q.size() == 0) check("unexpected_duty_change", 1, 0);
        else begin
          e = duty_q.pop_front();
          check("duty_r", duty_r, e.r);
          check("duty_g", duty_g, e.g);
          check("duty_b", duty_b, e.b);
          check("duty_time", cyc - start_cyc, e.t);
        end
        prev_r = duty_r; prev_g = duty_g; prev_b = duty_b;
      end
      if (step_done) begin
        if (done_q.size() == 0) check("unexpected_step_done", 1, 0);
        else begin
          e = done_q.pop_front();
          check("done_idx", step_idx, e.idx);
          check("done_r", duty_r, e.r);
          check("done_g", duty_g, e.g);
          check("done_b", duty_b, e.b);
          check("done_time", cyc - start_cyc, e.t);
        end
      end
    end
  end

  task automatic wr(input int a, input int r, input int g, input int b,
                    input int rate, input int hold);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_r    = DUTY_W'(r);
    cfg_g    = DUTY_W'(g);
    cfg_b    = DUTY_W'(b);
    cfg_rate = CNT_W'(rate);
    cfg_hold = CNT_W'(hold);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Leaves time at 1 unit after the edge that accepted start; start_cyc marks that edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy && n < limit);
    check("idle_timeout_busy", busy, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_duty_queue_left"}, duty_q.size(), 0);
    check({tag, "_done_queue_left"}, done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (100) @(negedge clk);
    check("rst_duty_r", duty_r, 0);
    check("rst_duty_g", duty_g, 0);
    check("rst_duty_b", duty_b, 0);
    check("rst_busy", busy, 0);
    check("rst_step_idx", step_idx, 0);
    check("rst_step_done", step_done, 0);

    // Ramp up at 300/tick, hold 2, then jump back to 0 via a zero entry.
    wr(0, 1200, 0, 0, 300, 2);
    push_d(4, 300, 0, 0);
    push_d(8, 600, 0, 0);
    push_d(12, 900, 0, 0);
    push_d(16, 1200, 0, 0);
    push_d(28, 0, 0, 0);
    push_done(25, 1, 1200, 0, 0);
    push_done(30, 1, 0, 0, 0);
    do_start();
    check("start_busy", busy, 1);
    wait_idle(200);
    check("ramp_end_idx", step_idx, 1);
    check_drained("ramp");

    // Non-dividing rate (no overshoot), clamp of 2000 to 1200, hold of one tick.
    wr(0, 20, 14, 0, 7, 0);
    wr(1, 2000, 0, 5, 0, 1);
    push_d(4, 7, 7, 0);
    push_d(8, 14, 14, 0);
    push_d(12, 20, 14, 0);
    push_d(16, 1200, 0, 5);
    push_done(14, 1, 20, 14, 0);
    push_done(21, 1, 1200, 0, 5);
    do_start();
    wait_idle(200);
    check_drained("clamp");

    // Looping: three full passes, then stop while reloading entry 0.
    wr(0, 100, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 0);
    loop_en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push_d(4 + 8 * p, 100, 0, 0);
      push_d(8 + 8 * p, 0, 0, 0);
      push_done(6 + 8 * p, 1, 100, 0, 0);
      push_done(10 + 8 * p, 0, 0, 0, 0);
    end
    do_start();
    repeat (26) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    loop_en = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_idx", step_idx, 0);
    repeat (20) @(negedge clk);
    check_drained("loop");

    // Stop mid-ramp freezes the duty; start+stop together stays idle.
    wr(0, 1000, 0, 0, 100, 0);
    push_d(4, 100, 0, 0);
    push_d(8, 200, 0, 0);
    push_d(12, 300, 0, 0);
    do_start();
    repeat (13) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("stop_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("stop_frozen_r", duty_r, 300);
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("start_stop_still_idle", busy, 0);
    check_drained("stop");

    // Reset mid-hold, then run the cleared table.
    wr(0, 50, 60, 70, 0, 5);
    push_d(4, 50, 60, 70);
    do_start();
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_duty_r", duty_r, 0);
    check("midrst_duty_g", duty_g, 0);
    check("midrst_duty_b", duty_b, 0);
    check("midrst_busy", busy, 0);
    check("midrst_idx", step_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_drained("midrst");
    push_done(3, 1, 0, 0, 0);
    push_done(6, 1, 0, 0, 0);
    do_start();
    wait_idle(100);
    check("cleared_end_idx", step_idx, 1);
    repeat (5) @(negedge clk);
    check_drained("cleared");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
